dual_port_ram_be: RTL and testbench

Parametrised true dual-port synchronous RAM: the successor to the project's fixed 16x1024 `mem`. It adds per-byte write enables, port enables, a selectable same-port read-during-write mode, deterministic same-address write collision resolution with a collision flag, and a post-reset clear sequencer that zeroes the array. It sits between the CPU datapath (port A) and the I/O/loader side (port B) as the system's main data/instruction store.

---
 rtl/dual_port_ram_be.sv | 111 +++++++++++
 tb/tb_dual_port_ram_be.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable same-port
// read-during-write, port-A-priority write collisions and a post-reset zeroing sweep.
module dual_port_ram_be #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  output logic [DATA_WIDTH-1:0]   out_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_b,
  output logic [DATA_WIDTH-1:0]   out_b,
  output logic                    busy,
  output logic                    collision
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic                  collision_q, collision_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  ready, wr_a, wr_b;
  logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) begin
        state_d = StReady;
      end
    end
  end

  always_comb begin
    ready    = (state_q == StReady);
    wr_a     = ready & en_a & we_a;
    wr_b     = ready & en_b & we_b;
    old_a    = mem_q[addr_a];
    old_b    = mem_q[addr_b];
    merged_a = old_a;
    merged_b = old_b;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (be_a[i]) merged_a[8*i +: 8] = data_a[8*i +: 8];
      if (be_b[i]) merged_b[8*i +: 8] = data_b[8*i +: 8];
    end
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    // Reads always see the pre-edge array, so cross-port reads return the old word.
    if (ready && en_a) out_a_d = (RDW_MODE != 0 && wr_a) ? merged_a : old_a;
    if (ready && en_b) out_b_d = (RDW_MODE != 0 && wr_b) ? merged_b : old_b;
    collision_d = wr_a & wr_b & (addr_a == addr_b) & (|(be_a & be_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= StClear;
      end else begin
        state_q <= StReady;
      end
      clr_cnt_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      collision_q <= collision_d;
    end
  end

  // Port A's byte writes are issued last so they override B on shared bytes.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (wr_b && be_b[i]) mem_q[addr_b][8*i +: 8] <= data_b[8*i +: 8];
      end
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (wr_a && be_a[i]) mem_q[addr_a][8*i +: 8] <= data_a[8*i +: 8];
      end
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign busy      = (state_q == StClear);
  assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: a read-first and a write-first instance share stimulus
// and are compared against a word-array reference model.
module tb_dual_port_ram_be;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en_a, we_a, en_b, we_b;
  logic [1:0] be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] out_a0, out_b0, out_a1, out_b1;
  logic busy0, busy1, coll0, coll1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_a0, exp_b0, exp_a1, exp_b1;
  logic exp_coll;

  always #5 clk = ~clk;

  dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .out_a(out_a0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .out_b(out_b0),
    .busy(busy0), .collision(coll0)
  );

  dual_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .out_a(out_a1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .out_b(out_b1),
    .busy(busy1), .collision(coll1)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 2; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Reference behaviour for one ready-state edge, using the inputs seen at that edge.
  task automatic model_edge();
    logic [DW-1:0] oa, ob;
    oa = mem_m[addr_a];
    ob = mem_m[addr_b];
    if (en_a) begin
      exp_a0 = oa;
      exp_a1 = we_a ? merge(oa, data_a, be_a) : oa;
    end
    if (en_b) begin
      exp_b0 = ob;
      exp_b1 = we_b ? merge(ob, data_b, be_b) : ob;
    end
    exp_coll = en_a && we_a && en_b && we_b && (addr_a == addr_b) && ((be_a & be_b) != 2'b00);
    if (en_b && we_b) mem_m[addr_b] = merge(mem_m[addr_b], data_b, be_b);
    if (en_a && we_a) mem_m[addr_a] = merge(mem_m[addr_a], data_a, be_a);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp_a0 = '0; exp_b0 = '0; exp_a1 = '0; exp_b1 = '0;
    exp_coll = 1'b0;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = '0; data_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = '0; data_b = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic raw_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (busy0 && cnt < 100) begin
      raw_tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    #1 rst_n = 1'b0;
    raw_tick();
    raw_tick();
    checks++;
    if ({busy0, busy1, coll0, coll1, out_a0, out_b0, out_a1, out_b1} !== {4'b1100, 64'h0}) begin
      errors++;
      $display("FAIL reset_state got busy=%b%b coll=%b%b outs=%h %h %h %h required busy=11 coll=00 outs=0",
               busy0, busy1, coll0, coll1, out_a0, out_b0, out_a1, out_b1);
    end
    rst_n = 1'b1;
    wait_sweep(cnt);
    checks++;
    if (cnt !== 16 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL clear_duration got %0d cycles (busy1=%b) required 16 cycles", cnt, busy1);
    end
    clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      en_a = 1'b1; addr_a = AW'(i);
      en_b = 1'b1; addr_b = AW'(DEPTH - 1 - i);
      tick();
      checks++;
      if ({out_a0, out_b0, out_a1, out_b1} !== 64'h0) begin
        errors++;
        $display("FAIL cleared_read addr %0d got %h %h %h %h required 0000", i,
                 out_a0, out_b0, out_a1, out_b1);
      end
    end
  endtask

  task automatic test_dual_write();
    idle();
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'h0; data_a = 16'hfefe;
    en_b = 1'b1; we_b = 1'b1; be_b = 2'b11; addr_b = 4'h1; data_b = 16'hefef;
    tick();
    idle();
    en_a = 1'b1; addr_a = 4'h1;
    en_b = 1'b1; addr_b = 4'h0;
    tick();
    checks++;
    if ({out_a0, out_b0, out_a1, out_b1} !== {16'hefef, 16'hfefe, 16'hefef, 16'hfefe}) begin
      errors++;
      $display("FAIL dual_write got a=%h/%h b=%h/%h required a=efef b=fefe",
               out_a0, out_a1, out_b0, out_b1);
    end
  endtask

  task automatic test_byte_enables();
    idle();
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'h2; data_a = 16'hbeaf;
    tick();
    data_a = 16'hdead; be_a = 2'b01;
    tick();
    idle();
    en_b = 1'b1; addr_b = 4'h2;
    tick();
    checks++;
    if ({out_b0, out_b1} !== {2{16'hbead}}) begin
      errors++;
      $display("FAIL byte_enable got %h/%h required bead", out_b0, out_b1);
    end
  endtask

  task automatic test_rdw();
    idle();
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'h3; data_a = 16'h1234;
    tick();
    data_a = 16'habcd;
    en_b = 1'b1; addr_b = 4'h3;
    tick();
    checks++;
    if ({out_a0, out_a1} !== {16'h1234, 16'habcd}) begin
      errors++;
      $display("FAIL same_port_rdw got mode0=%h mode1=%h required 1234 abcd", out_a0, out_a1);
    end
    checks++;
    if ({out_b0, out_b1} !== {2{16'h1234}}) begin
      errors++;
      $display("FAIL cross_port_rdw got mode0=%h mode1=%h required 1234", out_b0, out_b1);
    end
    idle();
    en_b = 1'b1; addr_b = 4'h3;
    tick();
    checks++;
    if ({out_b0, out_b1} !== {2{16'habcd}}) begin
      errors++;
      $display("FAIL rdw_readback got %h/%h required abcd", out_b0, out_b1);
    end
  endtask

  task automatic test_collision();
    logic [1:0] bes_b [2];
    logic       req_coll [2];
    bes_b[0] = 2'b11; req_coll[0] = 1'b1;
    bes_b[1] = 2'b01; req_coll[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle();
      en_a = 1'b1; we_a = 1'b1; be_a = 2'b10;     addr_a = 4'h2; data_a = 16'hbeaf;
      en_b = 1'b1; we_b = 1'b1; be_b = bes_b[k];  addr_b = 4'h2; data_b = 16'hdead;
      tick();
      checks++;
      if ({coll0, coll1} !== {2{req_coll[k]}}) begin
        errors++;
        $display("FAIL collision_flag case %0d got %b%b required %b", k, coll0, coll1, req_coll[k]);
      end
      idle();
      en_a = 1'b1; addr_a = 4'h2;
      tick();
      checks++;
      if ({coll0, coll1} !== 2'b00) begin
        errors++;
        $display("FAIL collision_pulse case %0d got %b%b required 00", k, coll0, coll1);
      end
      checks++;
      if ({out_a0, out_a1} !== {2{16'hbead}}) begin
        errors++;
        $display("FAIL collision_word case %0d got %h/%h required bead", k, out_a0, out_a1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    idle();
    rst_n = 1'b0;
    raw_tick();
    rst_n = 1'b1;
    repeat (5) raw_tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, busy1, out_a0, out_b0, out_a1, out_b1} !== {2'b11, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid_sweep got busy=%b%b outs=%h %h %h %h required busy=11 outs=0",
               busy0, busy1, out_a0, out_b0, out_a1, out_b1);
    end
    raw_tick();
    rst_n = 1'b1;
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'h7; data_a = 16'hffff;
    en_b = 1'b1; we_b = 1'b1; be_b = 2'b11; addr_b = 4'h8; data_b = 16'hffff;
    wait_sweep(cnt);
    idle();
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL restart_sweep got %0d cycles required 16", cnt);
    end
    checks++;
    if ({out_a0, out_b0, out_a1, out_b1} !== 64'h0) begin
      errors++;
      $display("FAIL sweep_outputs got %h %h %h %h required 0000", out_a0, out_b0, out_a1, out_b1);
    end
    clear_model();
    en_a = 1'b1; addr_a = 4'h7;
    en_b = 1'b1; addr_b = 4'h8;
    tick();
    checks++;
    if ({out_a0, out_b0, out_a1, out_b1} !== 64'h0) begin
      errors++;
      $display("FAIL sweep_ignores_requests got %h %h %h %h required 0000",
               out_a0, out_b0, out_a1, out_b1);
    end
    // Three cycles of traffic, the last with port A disabled.
    idle();
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 4'h1; data_a = 16'h5a5a;
    en_b = 1'b1; addr_b = 4'h2;
    tick();
    idle();
    en_a = 1'b1; addr_a = 4'h1;
    en_b = 1'b1; we_b = 1'b1; be_b = 2'b11; addr_b = 4'h2; data_b = 16'h1111;
    tick();
    idle();
    we_a = 1'b1; be_a = 2'b11; addr_a = 4'h2; data_a = 16'hffff;
    en_b = 1'b1; addr_b = 4'h1;
    tick();
    checks++;
    if ({out_a0, out_a1, out_b0, out_b1} !== {4{16'h5a5a}}) begin
      errors++;
      $display("FAIL port_disable_hold got a=%h/%h b=%h/%h required 5a5a",
               out_a0, out_a1, out_b0, out_b1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, coll0, out_a0, out_b0, out_a1, out_b1} !== {2'b10, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid_traffic got busy=%b coll=%b outs=%h %h %h %h required busy=1 outs=0",
               busy0, coll0, out_a0, out_b0, out_a1, out_b1);
    end
    idle();
    raw_tick();
    rst_n = 1'b1;
    wait_sweep(cnt);
    clear_model();
    en_a = 1'b1; addr_a = 4'h1;
    en_b = 1'b1; addr_b = 4'h2;
    tick();
    checks++;
    if (cnt !== 16 || {out_a0, out_b0, out_a1, out_b1} !== 64'h0) begin
      errors++;
      $display("FAIL post_traffic_clear got %0d cycles outs=%h %h %h %h required 16 cycles outs=0",
               cnt, out_a0, out_b0, out_a1, out_b1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      en_a   = ($urandom_range(0, 3) != 0);
      we_a   = 1'($urandom_range(0, 1));
      be_a   = 2'($urandom_range(0, 3));
      addr_a = (n % 4 == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      data_a = 16'($urandom);
      en_b   = ($urandom_range(0, 3) != 0);
      we_b   = 1'($urandom_range(0, 1));
      be_b   = 2'($urandom_range(0, 3));
      addr_b = (n % 4 == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 3));
      data_b = 16'($urandom);
      tick();
      checks++;
      if ({out_a0, out_b0} !== {exp_a0, exp_b0}) begin
        errors++;
        $display("FAIL random_rd_first iter %0d got %h %h required %h %h", n,
                 out_a0, out_b0, exp_a0, exp_b0);
      end
      checks++;
      if ({out_a1, out_b1} !== {exp_a1, exp_b1}) begin
        errors++;
        $display("FAIL random_wr_first iter %0d got %h %h required %h %h", n,
                 out_a1, out_b1, exp_a1, exp_b1);
      end
      checks++;
      if ({coll0, coll1} !== {2{exp_coll}}) begin
        errors++;
        $display("FAIL random_collision iter %0d got %b%b required %b", n, coll0, coll1, exp_coll);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_dual_write();
    test_byte_enables();
    test_rdw();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
